slot_reel_ctrl: RTL and testbench
=================================

Name: slot_reel_ctrl

Overview:
- Upstream stage for the win/lose display block: generates the three BCD reel digits (0..9) that feed its inc1/inc2/inc3 inputs.
- Start button sets all three reels spinning at a prescaled rate, each with a different step.
- Each stop-button press freezes the next reel in order 1→2→3.
- After the third stop, the held digits are flagged valid for win/lose evaluation.

Parameters:
- TICK_DIV, 4: clock cycles per reel advance tick. Legal range ≥2; benches use 2.
- STEP1, 1: mod-10 increment of reel1 per tick.
- STEP2, 3: mod-10 increment of reel2 per tick.
- STEP3, 7: mod-10 increment of reel3 per tick.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start button level, already synchronous to clk.
- stop  in  1  stop button level, already synchronous to clk.
- reel1  out  4  BCD digit, drives inc1 of the win/lose block.
- reel2  out  4  BCD digit, drives inc2.
- reel3  out  4  BCD digit, drives inc3.
- spinning  out  1  high while any reel is moving.
- result_valid  out  1  high while all reels are stopped after a completed spin.

Behaviour:
- Reset (rst_n low, async): state=IDLE; reel1/2/3=0; spinning=0; result_valid=0; prescaler=0; edge-detect registers=0.
- Edge detect: start_rise = start & ~start_q; stop_rise = stop & ~stop_q. Both are registered each clk. Held levels produce exactly one event.
- Prescaler: counts 0..TICK_DIV-1 while state ∈ {SPIN3, SPIN2, SPIN1}. tick=1 in the cycle count==TICK_DIV-1, then the count wraps to 0. The count is cleared to 0 on the cycle start_rise is accepted.
- Reel arithmetic: on tick, each moving reel does reel <= (reel + STEPk) mod 10. The sum is formed in 5 bits and 10 is subtracted if ≥10. Outputs never exceed 9. Stopped reels hold.
- States and transitions:
  - IDLE: start_rise → SPIN3. stop ignored.
  - SPIN3 (reels 1, 2, 3 moving): stop_rise → SPIN2.
  - SPIN2 (reels 2, 3 moving): stop_rise → SPIN1.
  - SPIN1 (reel 3 moving): stop_rise → DONE.
  - DONE: start_rise → SPIN3. stop ignored.
- Stop latency: in the cycle stop_rise is seen, the reel being stopped does NOT advance, even if tick=1. Its frozen value is the one present at that clock edge. Other still-moving reels advance normally on that tick.
- spinning = 1 in SPIN3/SPIN2/SPIN1, 0 otherwise. It is registered with the state and changes on the same edge as the state.
- result_valid = 1 only in DONE. It drops on the edge entering SPIN3.
- New spin from DONE or IDLE: reels resume from their held values and are not cleared.
- start_rise while spinning: ignored, no prescaler clear.
- Simultaneous start_rise and stop_rise: in IDLE/DONE, start wins. In SPIN states, stop is processed and start ignored.
- Reset asserted mid-spin: immediate return to reset values. The first start after release behaves as from power-up.

Decomposition:
- Package slot_pkg holds:
  - state enum: IDLE, SPIN3, SPIN2, SPIN1, DONE.
  - BCD_MAX=9.
  - reel width constant REEL_W=4.
- Sub-module reel_counter, instantiated three times:
  - parameter STEP.
  - inputs clk, rst_n, adv (tick & this reel moving & not being stopped this cycle).
  - output 4-bit digit.
  - implements the mod-10 add.
- FSM, prescaler and edge detect stay in slot_reel_ctrl.

Test Plan (TICK_DIV=2):
- Reset:
  - Stimulus: rst_n low, start/stop high.
  - Required: reels 0/0/0, spinning=0, result_valid=0, no motion.
  - Stimulus: release rst_n with start still high.
  - Required: no start event until start goes low then high.
- Spin arithmetic:
  - Stimulus: start pulse; run 4 ticks (8 clks).
  - Required: reels 4/2/8.
  - Stimulus: continue to 10 ticks.
  - Required: reels 0/0/0 (wrap). No value >9 observed at any cycle.
- Ordered stop:
  - Stimulus: from 4/2/8, press stop.
  - Required: reel1 frozen at 4.
  - Stimulus: after 1 more tick.
  - Required: reels 4/5/5.
  - Stimulus: stop, 1 tick, stop.
  - Required: final 4/5/2, state DONE, result_valid=1, spinning=0.
- Stop on tick cycle:
  - Stimulus: stop_rise coincides with tick.
  - Required: stopped reel keeps its pre-tick value; the other moving reels advance.
- Ignored events:
  - Stimulus: stop in IDLE/DONE.
  - Required: no change.
  - Stimulus: held start level in SPIN2.
  - Required: no restart.
  - Stimulus: start and stop rising together in DONE.
  - Required: new spin from held digits, result_valid falls on that edge.
- Async reset mid-spin:
  - Stimulus: rst_n low between clock edges in SPIN2.
  - Required: outputs go to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot reel controller.
package slot_pkg;

    typedef enum logic [2:0] {IDLE, SPIN3, SPIN2, SPIN1, DONE} state_e;

    localparam int REEL_W  = 4;
    localparam int BCD_MAX = 9;

    // Mod-10 add: the sum is formed one bit wider so a single subtract folds it back into 0..9.
    function automatic logic [REEL_W-1:0] bcd_add(input logic [REEL_W-1:0] a, input int step);
        logic [REEL_W:0] s;
        s = {1'b0, a} + (REEL_W+1)'(step);
        if (s > (REEL_W+1)'(BCD_MAX))
            s = s - (REEL_W+1)'(BCD_MAX + 1);
        return s[REEL_W-1:0];
    endfunction

endpackage

// File: rtl/slot_reel_ctrl_if.sv
// Button inputs and reel/status outputs of the slot reel controller.
interface slot_reel_ctrl_if
    import slot_pkg::*;
();
    logic              start;
    logic              stop;
    logic [REEL_W-1:0] reel1;
    logic [REEL_W-1:0] reel2;
    logic [REEL_W-1:0] reel3;
    logic              spinning;
    logic              result_valid;

    modport master (output start, stop,
                    input  reel1, reel2, reel3, spinning, result_valid);
    modport slave  (input  start, stop,
                    output reel1, reel2, reel3, spinning, result_valid);
endinterface

// File: rtl/reel_counter.sv
// One BCD reel: advances by STEP (mod 10) on each adv pulse, otherwise holds.
module reel_counter
    import slot_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv_i,
    output logic [REEL_W-1:0] digit_o
);
    logic [REEL_W-1:0] digit_q, digit_d;

    always_comb digit_d = adv_i ? bcd_add(digit_q, STEP) : digit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) digit_q <= '0;
        else        digit_q <= digit_d;
    end

    assign digit_o = digit_q;
endmodule

// File: rtl/slot_reel_ctrl.sv
// Slot reel controller: start spins all three reels, each stop press freezes the next reel in order 1-2-3.
module slot_reel_ctrl
    import slot_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int STEP1    = 1,
    parameter int STEP2    = 3,
    parameter int STEP3    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    slot_reel_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(TICK_DIV);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, stop_q, start_arm_q;
    logic             start_rise, stop_rise, spin, tick;
    logic [2:0]       adv;

    // start_arm_q blocks a start level held through reset from counting as a press.
    assign start_rise = bus.start & ~start_q & start_arm_q;
    assign stop_rise  = bus.stop & ~stop_q;
    assign spin       = (state_q == SPIN3) || (state_q == SPIN2) || (state_q == SPIN1);
    assign tick       = spin && (cnt_q == CNT_W'(TICK_DIV - 1));

    // Prescaler runs only while spinning; outside SPIN it sits at 0, so an accepted start always clears it.
    always_comb begin
        state_d = state_q;
        adv     = '0;
        cnt_d   = '0;
        if (spin) cnt_d = tick ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE, DONE: if (start_rise) state_d = SPIN3;
            SPIN3: begin
                adv = {tick, tick, tick & ~stop_rise};
                if (stop_rise) state_d = SPIN2;
            end
            SPIN2: begin
                adv = {tick, tick & ~stop_rise, 1'b0};
                if (stop_rise) state_d = SPIN1;
            end
            SPIN1: begin
                adv = {tick & ~stop_rise, 2'b00};
                if (stop_rise) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            start_arm_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= bus.start;
            stop_q      <= bus.stop;
            start_arm_q <= start_arm_q | ~bus.start;
        end
    end

    assign bus.spinning     = spin;
    assign bus.result_valid = (state_q == DONE);

    reel_counter #(.STEP(STEP1)) u_reel1 (.clk(clk), .rst_n(rst_n), .adv_i(adv[0]), .digit_o(bus.reel1));
    reel_counter #(.STEP(STEP2)) u_reel2 (.clk(clk), .rst_n(rst_n), .adv_i(adv[1]), .digit_o(bus.reel2));
    reel_counter #(.STEP(STEP3)) u_reel3 (.clk(clk), .rst_n(rst_n), .adv_i(adv[2]), .digit_o(bus.reel3));
endmodule

// File: tb/tb_slot_reel_ctrl.sv
// Directed bench for slot_reel_ctrl with TICK_DIV=2; expected reels are hand-computed mod-10 sums.
module tb_slot_reel_ctrl;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    logic over9;

    slot_reel_ctrl_if bus ();

    slot_reel_ctrl #(.TICK_DIV(2), .STEP1(1), .STEP2(3), .STEP3(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.reel1 > 4'd9 || bus.reel2 > 4'd9 || bus.reel3 > 4'd9) over9 <= 1'b1;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [11:0] reels, input logic sp, input logic rv);
        chk({tag, ".reels"}, {bus.reel1, bus.reel2, bus.reel3}, reels);
        chk({tag, ".flags"}, {10'd0, bus.spinning, bus.result_valid}, {10'd0, sp, rv});
    endtask

    task automatic steps(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests = 0; fails = 0; over9 = 1'b0;
        rst_n = 1'b0; bus.start = 1'b1; bus.stop = 1'b1;
        steps(3);
        chk_all("reset", 12'h000, 1'b0, 1'b0);
        rst_n = 1'b1;
        steps(4);
        chk_all("held_start_after_reset", 12'h000, 1'b0, 1'b0);
        bus.stop = 1'b0; steps(1);
        bus.stop = 1'b1; steps(2);
        chk_all("stop_in_idle", 12'h000, 1'b0, 1'b0);
        bus.stop = 1'b0; bus.start = 1'b0; steps(1);
        bus.start = 1'b1; steps(1);
        chk_all("start_accept", 12'h000, 1'b1, 1'b0);
        bus.start = 1'b0;
        steps(8);
        chk_all("four_ticks", 12'h428, 1'b1, 1'b0);
        steps(12);
        chk_all("ten_ticks_wrap", 12'h000, 1'b1, 1'b0);
        steps(8);
        chk_all("fourteen_ticks", 12'h428, 1'b1, 1'b0);

        bus.stop = 1'b1; steps(1);
        chk_all("stop1_frozen", 12'h428, 1'b1, 1'b0);
        bus.stop = 1'b0; steps(1);
        chk_all("after_stop1_tick", 12'h455, 1'b1, 1'b0);
        bus.stop = 1'b1; steps(1);
        bus.stop = 1'b0; steps(1);
        chk_all("after_stop2_tick", 12'h452, 1'b1, 1'b0);
        bus.stop = 1'b1; steps(1);
        chk_all("done", 12'h452, 1'b0, 1'b1);
        bus.stop = 1'b0; steps(1);
        bus.stop = 1'b1; steps(2);
        chk_all("stop_in_done", 12'h452, 1'b0, 1'b1);
        bus.stop = 1'b0; steps(1);

        bus.start = 1'b1; bus.stop = 1'b1; steps(1);
        chk_all("start_stop_in_done", 12'h452, 1'b1, 1'b0);
        bus.start = 1'b0; bus.stop = 1'b0; steps(1);
        chk_all("respin_no_tick", 12'h452, 1'b1, 1'b0);
        bus.stop = 1'b1; steps(1);
        chk_all("stop_on_tick", 12'h489, 1'b1, 1'b0);
        bus.stop = 1'b0; steps(1);
        bus.start = 1'b1; steps(3);
        chk_all("held_start_in_spin2", 12'h443, 1'b1, 1'b0);

        bus.stop = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_all("async_reset", 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        steps(2);
        chk_all("in_reset_no_motion", 12'h000, 1'b0, 1'b0);
        rst_n = 1'b1; steps(3);
        chk_all("release_held_start", 12'h000, 1'b0, 1'b0);
        bus.start = 1'b0; bus.stop = 1'b0; steps(1);
        bus.start = 1'b1; steps(1);
        bus.start = 1'b0; steps(8);
        chk_all("spin_after_reset", 12'h428, 1'b1, 1'b0);
        chk("no_digit_over_9", {11'd0, over9}, 12'h000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
